// File: rtl/ntt_to_point_if.sv
// Beat input, FIFO write and coarse pointer signals between the NTT core,
// the output FIFOs and the host-side drain.
interface ntt_to_point_if #(
   parameter int NLANE    = 16,
   parameter int NPPCH    = 2,
   parameter int POINT_W  = 64,
   parameter int FINE_W   = 4,
   parameter int COARSE_W = 3
);
   logic                                              valid_i;
   logic [NLANE/2-1:0][NPPCH-1:0][1:0][POINT_W-1:0]   x_i;
   logic                                              hold_o;
   logic [NLANE-1:0][NPPCH-1:0]                       we_o;
   logic [NLANE-1:0][NPPCH-1:0][FINE_W-1:0]           waddr_o;
   logic [NLANE-1:0][NPPCH-1:0][POINT_W-1:0]          wdata_o;
   logic [NLANE-1:0][COARSE_W-1:0]                    wcoarse_o;
   logic [COARSE_W-1:0]                               rcoarse_i;
   logic                                              ovf_o;

   modport slave (
      input  valid_i, x_i, rcoarse_i,
      output hold_o, we_o, waddr_o, wdata_o, wcoarse_o, ovf_o
   );

   modport master (
      output valid_i, x_i, rcoarse_i,
      input  hold_o, we_o, waddr_o, wdata_o, wcoarse_o, ovf_o
   );
endinterface

// File: rtl/ntt_to_point.sv
// NTT output DMA stage: undoes the feeder's lane rotation and inner swap, writes
// per-lane FIFOs, publishes a Gray write pointer and throttles the launcher.
module ntt_to_point #(
   parameter int NLANE    = 16,
   parameter int NPPCH    = 2,
   parameter int POINT_W  = 64,
   parameter int FINE_W   = 4,
   parameter int COARSE_W = 3
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   ntt_to_point_if.slave  bus
);
   localparam int NPAIR = NLANE / 2;
   localparam int LP    = $clog2(NPAIR);
   localparam int CYC_W = FINE_W + COARSE_W;
   localparam logic [COARSE_W-1:0] FULL_TH = COARSE_W'(1 << (COARSE_W - 1));
   localparam logic [COARSE_W-1:0] HOLD_TH = COARSE_W'((1 << (COARSE_W - 1)) - 1);
   localparam logic [FINE_W-1:0]   FINE_LAST = '1;

   typedef logic [NPAIR-1:0][NPPCH-1:0][1:0][POINT_W-1:0] beat_t;
   typedef logic [NLANE-1:0][NPPCH-1:0][POINT_W-1:0]      lanes_t;

   function automatic logic [COARSE_W-1:0] bin2gray(input logic [COARSE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [COARSE_W-1:0] gray2bin(input logic [COARSE_W-1:0] g);
      logic [COARSE_W-1:0] b;
      b[COARSE_W-1] = g[COARSE_W-1];
      for (int i = COARSE_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [CYC_W-1:0]    cnt_q, cnt_d;
   logic                s1_v_q, s1_v_d;
   logic [CYC_W-1:0]    s1_cyc_q, s1_cyc_d;
   beat_t               s1_x_q, s1_x_d;
   logic                s2_v_q, s2_v_d;
   logic [CYC_W-1:0]    s2_cyc_q, s2_cyc_d;
   lanes_t              s2_data_q, s2_data_d;
   logic                we_q, we_d;
   logic [FINE_W-1:0]   waddr_q, waddr_d;
   lanes_t              wdata_q, wdata_d;
   logic [COARSE_W-1:0] wc_q, wc_d;
   logic [COARSE_W-1:0] wcoarse_q, wcoarse_d;
   logic [COARSE_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [COARSE_W-1:0] rc_q, rc_d;
   logic                hold_q, hold_d;
   logic                ovf_q, ovf_d;

   beat_t               rot;
   logic [LP-1:0]       s1_s, src;
   logic                s1_swap;
   logic [COARSE_W-1:0] used_s1, used_s2;
   logic                drop, wr;

   always_comb begin
      cnt_d    = cnt_q;
      s1_v_d   = bus.valid_i;
      s1_cyc_d = s1_cyc_q;
      s1_x_d   = s1_x_q;
      if (bus.valid_i) begin
         cnt_d    = cnt_q + CYC_W'(1);
         s1_cyc_d = cnt_q;
         s1_x_d   = bus.x_i;
      end
   end

   // Left rotation by s undoes the feeder's right rotation; then the inner pair swaps back.
   always_comb begin
      s1_s    = s1_cyc_q[LP-1:0];
      s1_swap = s1_cyc_q[LP];
      rot     = '0;
      src     = '0;
      for (int k = 0; k < NPAIR; k++) begin
         src    = LP'(k) - s1_s;
         rot[k] = s1_x_q[src];
      end
      s2_v_d    = s1_v_q;
      s2_cyc_d  = s2_cyc_q;
      s2_data_d = s2_data_q;
      if (s1_v_q) begin
         s2_cyc_d = s1_cyc_q;
         for (int lo = 0; lo < NPAIR; lo++) begin
            for (int p = 0; p < NPPCH; p++) begin
               s2_data_d[2*lo][p]   = s1_swap ? rot[lo][p][1] : rot[lo][p][0];
               s2_data_d[2*lo+1][p] = s1_swap ? rot[lo][p][0] : rot[lo][p][1];
            end
         end
      end
   end

   always_comb begin
      used_s2 = s2_cyc_q[CYC_W-1:FINE_W] - rc_q;
      used_s1 = s1_cyc_q[CYC_W-1:FINE_W] - rc_q;
      drop    = s2_v_q && (used_s2 >= FULL_TH);
      wr      = s2_v_q && !drop;
      we_d    = wr;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      wc_d    = wc_q;
      if (wr) begin
         waddr_d = s2_cyc_q[FINE_W-1:0];
         wdata_d = s2_data_q;
         if (s2_cyc_q[FINE_W-1:0] == FINE_LAST) wc_d = wc_q + COARSE_W'(1);
      end
      wcoarse_d = bin2gray(wc_q);
      sync1_d   = bus.rcoarse_i;
      sync2_d   = sync1_q;
      rc_d      = gray2bin(sync2_q);
      // One block of slack beyond the hold threshold absorbs in-flight launcher beats.
      hold_d    = used_s1 >= HOLD_TH;
      ovf_d     = ovf_q | drop;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         s1_v_q    <= 1'b0;
         s1_cyc_q  <= '0;
         s1_x_q    <= '0;
         s2_v_q    <= 1'b0;
         s2_cyc_q  <= '0;
         s2_data_q <= '0;
         we_q      <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
         wc_q      <= '0;
         wcoarse_q <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         rc_q      <= '0;
         hold_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         s1_v_q    <= s1_v_d;
         s1_cyc_q  <= s1_cyc_d;
         s1_x_q    <= s1_x_d;
         s2_v_q    <= s2_v_d;
         s2_cyc_q  <= s2_cyc_d;
         s2_data_q <= s2_data_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         wc_q      <= wc_d;
         wcoarse_q <= wcoarse_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         rc_q      <= rc_d;
         hold_q    <= hold_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.hold_o    = hold_q;
   assign bus.we_o      = {(NLANE*NPPCH){we_q}};
   assign bus.waddr_o   = {(NLANE*NPPCH){waddr_q}};
   assign bus.wdata_o   = wdata_q;
   assign bus.wcoarse_o = {NLANE{wcoarse_q}};
   assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_ntt_to_point.sv
// Directed bench for ntt_to_point: lane unshift, FIFO addressing, block commit,
// hold/overflow throttling, pointer wrap and asynchronous reset.
module tb_ntt_to_point;
   localparam int NLANE    = 16;
   localparam int NPPCH    = 2;
   localparam int POINT_W  = 64;
   localparam int FINE_W   = 4;
   localparam int COARSE_W = 3;

   typedef struct {
      bit v;
      int c;
      bit wr;
   } beat_rec_t;

   logic clk_i;
   logic rst_ni;
   int   n_vec;
   int   n_err;
   bit   exp_ovf;
   beat_rec_t pend[$];

   ntt_to_point_if #(.NLANE(NLANE), .NPPCH(NPPCH), .POINT_W(POINT_W),
                     .FINE_W(FINE_W), .COARSE_W(COARSE_W)) bus ();

   ntt_to_point #(.NLANE(NLANE), .NPPCH(NPPCH), .POINT_W(POINT_W),
                  .FINE_W(FINE_W), .COARSE_W(COARSE_W)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] pt(input int c, input int lo, input int p, input int li);
      return 64'hC0DE_0000_0000_0000 | (64'(c) << 24) | (64'(lo) << 16) | (64'(p) << 8) | 64'(li);
   endfunction

   function automatic logic [COARSE_W-1:0] gray(input int b);
      logic [COARSE_W-1:0] v;
      v = COARSE_W'(b);
      return v ^ (v >> 1);
   endfunction

   // Expected FIFO write for a beat, mapping each source point forward to its lane.
   task automatic check_pop(input beat_rec_t b);
      logic [NLANE*NPPCH-1:0] we_exp;
      int s, sw, dest;
      if (b.v && !b.wr) exp_ovf = 1'b1;
      we_exp = (b.v && b.wr) ? '1 : '0;
      chk("we", 64'(bus.we_o), 64'(we_exp));
      if (b.v && b.wr) begin
         s  = b.c % 8;
         sw = (b.c / 8) % 2;
         for (int l = 0; l < NLANE; l++)
            for (int p = 0; p < NPPCH; p++)
               chk("waddr", 64'(bus.waddr_o[l][p]), 64'(b.c % 16));
         for (int lo = 0; lo < NLANE/2; lo++)
            for (int p = 0; p < NPPCH; p++)
               for (int li = 0; li < 2; li++) begin
                  dest = 2 * ((lo + s) % (NLANE/2)) + (li ^ sw);
                  chk("wdata", bus.wdata_o[dest][p], pt(b.c, lo, p, li));
               end
      end
   endtask

   // Drive one cycle; the beat driven two ticks earlier is visible after this edge.
   task automatic tick(input bit v, input int c, input bit wr);
      beat_rec_t r;
      bus.valid_i = v;
      if (v)
         for (int lo = 0; lo < NLANE/2; lo++)
            for (int p = 0; p < NPPCH; p++)
               for (int li = 0; li < 2; li++)
                  bus.x_i[lo][p][li] = pt(c, lo, p, li);
      r.v  = v;
      r.c  = c;
      r.wr = wr;
      pend.push_back(r);
      @(posedge clk_i);
      #1;
      if (pend.size() == 3) check_pop(pend.pop_front());
      chk("ovf", 64'(bus.ovf_o), 64'(exp_ovf));
   endtask

   task automatic chk_rst_outputs();
      chk("rst_hold", 64'(bus.hold_o), 64'd0);
      chk("rst_we", 64'(bus.we_o), 64'd0);
      chk("rst_waddr", 64'(|bus.waddr_o), 64'd0);
      chk("rst_wdata", 64'(|bus.wdata_o), 64'd0);
      chk("rst_wcoarse", 64'(|bus.wcoarse_o), 64'd0);
      chk("rst_ovf", 64'(bus.ovf_o), 64'd0);
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      exp_ovf       = 1'b0;
      rst_ni        = 1'b0;
      bus.valid_i   = 1'b0;
      bus.x_i       = '0;
      bus.rcoarse_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_rst_outputs();
      rst_ni = 1'b1;

      // Block 0 with the read pointer parked at 0, then its commit timing.
      for (int c = 0; c < 16; c++) tick(1'b1, c, 1'b1);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
      chk("wcoarse_pre", 64'(bus.wcoarse_o[0]), 64'd0);
      tick(1'b0, 0, 1'b0);
      for (int l = 0; l < NLANE; l++) chk("wcoarse_b1", 64'(bus.wcoarse_o[l]), 64'(3'b001));
      chk("hold_b0", 64'(bus.hold_o), 64'd0);

      // Fill to the FIFO limit; beat 64 must be dropped.
      for (int c = 16; c < 64; c++) begin
         tick(1'b1, c, 1'b1);
         if (c == 48) chk("hold_before_b3", 64'(bus.hold_o), 64'd0);
         if (c == 49) chk("hold_in_b3", 64'(bus.hold_o), 64'd1);
      end
      tick(1'b1, 64, 1'b0);
      repeat (3) tick(1'b0, 0, 1'b0);
      chk("wcoarse_b4", 64'(bus.wcoarse_o[NLANE-1]), 64'(3'b110));
      chk("hold_full", 64'(bus.hold_o), 64'd1);

      // Drain advances in Gray steps 1, 3, 2.
      bus.rcoarse_i = 3'b001;
      repeat (5) tick(1'b0, 0, 1'b0);
      chk("hold_used3", 64'(bus.hold_o), 64'd1);
      bus.rcoarse_i = 3'b011;
      repeat (3) tick(1'b0, 0, 1'b0);
      chk("hold_lag", 64'(bus.hold_o), 64'd1);
      tick(1'b0, 0, 1'b0);
      chk("hold_fall", 64'(bus.hold_o), 64'd0);
      bus.rcoarse_i = 3'b010;
      repeat (4) tick(1'b0, 0, 1'b0);
      for (int c = 65; c < 80; c++) tick(1'b1, c, 1'b1);
      repeat (3) tick(1'b0, 0, 1'b0);
      chk("wcoarse_b5", 64'(bus.wcoarse_o[3]), 64'(3'b111));
      chk("hold_resumed", 64'(bus.hold_o), 64'd0);

      // Reset mid-block while beat with fine=7 is on the bus.
      for (int c = 80; c < 87; c++) tick(1'b1, c, 1'b1);
      bus.valid_i = 1'b1;
      #3 rst_ni = 1'b0;
      #1;
      chk_rst_outputs();
      bus.valid_i   = 1'b0;
      bus.rcoarse_i = '0;
      pend.delete();
      exp_ovf = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Full pointer wrap with the drain keeping up.
      for (int b = 0; b < 144; b++) begin
         bus.rcoarse_i = gray(((b % 128) / 16) % 8);
         tick(1'b1, b % 128, 1'b1);
         if (b >= 17 && b % 16 == 1) chk("wcoarse_hold", 64'(bus.wcoarse_o[0]), 64'(gray(b / 16 - 1)));
         if (b >= 18 && b % 16 == 2) chk("wcoarse_step", 64'(bus.wcoarse_o[0]), 64'(gray(b / 16)));
         if (b == 130) chk("hold_wrap", 64'(bus.hold_o), 64'd0);
      end
      repeat (3) tick(1'b0, 0, 1'b0);
      chk("wcoarse_wrap", 64'(bus.wcoarse_o[NLANE-1]), 64'(3'b001));
      chk("hold_end", 64'(bus.hold_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
